// File: rtl/sar_search_if.sv
// sar_search_if
//   Bundles the start/result handshake and the comparator flag/trial signals
//   of the successive-approximation search controller.
//   master modport: the search controller (drives guess and the status outputs).
//   slave modport : the environment (control FSM plus the comparator).
//   Signals: start, gt, eq, lt (into controller); guess, busy, done, result,
//   found, err (out of controller).
interface sar_search_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  modport master (
    input  start, gt, eq, lt,
    output guess, busy, done, result, found, err
  );

  modport slave (
    output start, gt, eq, lt,
    input  guess, busy, done, result, found, err
  );
endinterface

// File: rtl/sar_search.sv
// sar_search
//   Successive-approximation search controller. Drives the b operand of an
//   external combinational magnitude comparator one trial value per clock,
//   MSB first, and recovers the unknown value on the comparator a operand.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - sar_search_if.master: start, gt/eq/lt in; guess, busy, done,
//              result, found, err out
//   Build option:
//     SAR_SEARCH_EARLY_EXIT_EN - when defined, an eq flag ends the search at
//     once; otherwise eq keeps the bit like gt and all WIDTH probes run.
module sar_search #(
  parameter int WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  sar_search_if.master  bus
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] guess_w;
  logic [WIDTH-1:0] acc_next;

  // A well-behaved comparator asserts exactly one of its three flags.
  function automatic logic flags_onehot(input logic g, input logic e, input logic l);
    return ({g, e, l} == 3'b100) || ({g, e, l} == 3'b010) || ({g, e, l} == 3'b001);
  endfunction

  // Trial value comes purely from registers so the comparator loop has no
  // combinational path back through the flags.
  assign guess_w = (state_q == PROBE) ? (acc_q | (ONE << k_q)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    k_d      = k_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    // Without early exit, eq keeps the bit exactly like gt.
    acc_next = (bus.gt || bus.eq) ? guess_w : acc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = PROBE;
          k_d      = KW'(WIDTH - 1);
          acc_d    = '0;
          result_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
        end
      end
      PROBE: begin
        if (!flags_onehot(bus.gt, bus.eq, bus.lt)) begin
          state_d  = DONE;
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = acc_q;
        end else if (EARLY_EXIT && bus.eq) begin
          state_d  = DONE;
          acc_d    = guess_w;
          result_d = guess_w;
          found_d  = 1'b1;
        end else begin
          acc_d = acc_next;
          if (k_q == '0) begin
            state_d  = DONE;
            result_d = acc_next;
            found_d  = 1'b1;
          end else begin
            k_d = k_q - KW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.guess  = guess_w;
  assign bus.busy   = (state_q == PROBE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search
//   Directed bench for sar_search with WIDTH=3 and a behavioural comparator
//   (a = unknown, b = guess). Expected guesses, probe counts and results are
//   hand-computed per scenario.
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic [2:0] unk;
  logic       fault_on;
  int         checks;
  int         errors;

  sar_search_if #(.WIDTH(3)) bus ();

  sar_search #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator; the fault mode raises gt and eq together on the first probe.
  assign bus.gt = (fault_on && bus.guess == 3'b100) ? 1'b1 : (unk >  bus.guess);
  assign bus.eq = (fault_on && bus.guess == 3'b100) ? 1'b1 : (unk == bus.guess);
  assign bus.lt = (fault_on && bus.guess == 3'b100) ? 1'b0 : (unk <  bus.guess);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_guess"},  32'(bus.guess),  32'd0);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_found"},  32'(bus.found),  32'd0);
    check({tag, "_err"},    32'(bus.err),    32'd0);
  endtask

  // eg packs up to four expected guesses, first guess in the top bits.
  task automatic do_search(input string tag, input logic [2:0] u, input bit flt,
                           input logic [11:0] eg, input int en,
                           input logic [2:0] er, input bit ef, input bit ee);
    int         n;
    int         cyc;
    logic [2:0] gs [4];
    for (int i = 0; i < 4; i++) gs[i] = 3'b000;
    unk      = u;
    fault_on = flt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    // First probe cycle: previous status must already be cleared.
    check({tag, "_clr"}, 32'({bus.result, bus.found, bus.err}), 32'd0);
    n   = 0;
    cyc = 0;
    while (!bus.done && cyc < 12) begin
      if (bus.busy) begin
        if (n < 4) gs[n] = bus.guess;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"},   32'(bus.done), 32'd1);
    check({tag, "_busy"},   32'(bus.busy), 32'd0);
    check({tag, "_probes"}, 32'(n),        32'(en));
    for (int i = 0; i < en; i++) begin
      if (i < n && i < 4) check({tag, "_guess"}, 32'(gs[i]), 32'(eg[11 - 3*i -: 3]));
    end
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_found"},  32'(bus.found),  32'(ef));
    check({tag, "_err"},    32'(bus.err),    32'(ee));
    fault_on = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.done),   32'd0);
    check({tag, "_hold"},  32'(bus.result), 32'(er));
  endtask

  initial begin
    int dcnt;
    int cyc;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    unk       = 3'd0;
    fault_on  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    do_search("u5", 3'd5, 1'b0, {3'b100, 3'b110, 3'b101, 3'b000}, 3, 3'b101, 1'b1, 1'b0);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
    do_search("u6", 3'd6, 1'b0, {3'b100, 3'b110, 3'b000, 3'b000}, 2, 3'b110, 1'b1, 1'b0);
`else
    do_search("u6", 3'd6, 1'b0, {3'b100, 3'b110, 3'b111, 3'b000}, 3, 3'b110, 1'b1, 1'b0);
`endif
    do_search("u0", 3'd0, 1'b0, {3'b100, 3'b010, 3'b001, 3'b000}, 3, 3'b000, 1'b1, 1'b0);
    do_search("u7", 3'd7, 1'b0, {3'b100, 3'b110, 3'b111, 3'b000}, 3, 3'b111, 1'b1, 1'b0);
    do_search("flt", 3'd3, 1'b1, {3'b100, 3'b000, 3'b000, 3'b000}, 1, 3'b000, 1'b0, 1'b1);
    do_search("u3", 3'd3, 1'b0, {3'b100, 3'b010, 3'b011, 3'b000}, 3, 3'b011, 1'b1, 1'b0);

    // Reset during the second probe of unknown=5.
    unk = 3'd5;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_probe2_busy",  32'(bus.busy),  32'd1);
    check("rst_probe2_guess", 32'(bus.guess), 32'd6);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    do_search("u5b", 3'd5, 1'b0, {3'b100, 3'b110, 3'b101, 3'b000}, 3, 3'b101, 1'b1, 1'b0);

    // start kept high through PROBE and DONE: one search, one done pulse.
    unk  = 3'd7;
    dcnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
      bus.start = bus.busy || bus.done;
    end
    check("busy_start_dones", 32'(dcnt), 32'd1);
    check("busy_start_idle",  32'(bus.busy), 32'd0);

    // start held continuously: restart after exactly one IDLE cycle.
    bus.start = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!bus.done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("held_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("held_idle_busy", 32'(bus.busy), 32'd0);
    check("held_idle_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("held_restart_busy",  32'(bus.busy),  32'd1);
    check("held_restart_guess", 32'(bus.guess), 32'd4);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("held_done2",   32'(bus.done),   32'd1);
    check("held_result2", 32'(bus.result), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
